add_arbiter: RTL and testbench

ADD_ARBITER -- requirements
Module: add_arbiter

---
 rtl/add_arbiter_pkg.sv | 16 +
 rtl/add_arbiter_add_circuit.sv | 25 ++
 rtl/add_arbiter.sv | 109 ++++++++++
 tb/tb_add_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/add_arbiter_pkg.sv
// Shared definitions for the two-port add/sub arbiter.
//   state_t : FSM encoding used by add_arbiter
//   DW_DEF  : default operand/result width (only 32 is supported)
//   CW_DEF  : default width of the completed-operation counter
package add_arbiter_pkg;

  localparam int DW_DEF = 32;
  localparam int CW_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/add_arbiter_add_circuit.sv
// Combinational DW-bit adder/subtractor with signed overflow flag.
//   a, b     : operands
//   sub      : 1 = a - b (computed as a + ~b + 1), 0 = a + b
//   result   : wrapped two's complement result
//   overflow : signed overflow of the operation
module add_circuit
  import add_arbiter_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          sub,
  output logic [DW-1:0] result,
  output logic          overflow
);

  logic [DW-1:0] b_eff;

  assign b_eff  = sub ? ~b : b;
  assign result = a + b_eff + {{(DW-1){1'b0}}, sub};
  // Overflow judged against the effective (possibly inverted) B operand.
  assign overflow = (a[DW-1] == b_eff[DW-1]) && (result[DW-1] != a[DW-1]);

endmodule

// File: rtl/add_arbiter.sv
// Two requesters share one adder/subtractor through a round-robin arbiter.
// One operation at a time: IDLE (grant) -> EXEC (compute) -> RESP (hand off).
//   clock, reset_n           : clock, async active-low reset
//   reqN_valid/ready         : request handshake, ready only in IDLE for grantee
//   reqN_a/b/sub             : operands and add/sub select
//   rsp_valid/ready          : response handshake
//   rsp_id/result/overflow   : granted port, result, signed overflow
//   busy                     : state is not IDLE
//   ops_done                 : saturating count of handed-off responses
module add_arbiter
  import add_arbiter_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_b,
  input  logic          req0_sub,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_b,
  input  logic          req1_sub,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_id,
  output logic [DW-1:0] rsp_result,
  output logic          rsp_overflow,
  output logic          busy,
  output logic [CW-1:0] ops_done
);

  state_t        state, state_nxt;
  logic          last_grant;
  logic          grant_any, grant_id;
  logic [DW-1:0] op_a, op_b;
  logic          op_sub, op_id;
  logic [DW-1:0] sum;
  logic          sum_ovf;

  add_circuit #(.DW(DW)) u_add (
    .a        (op_a),
    .b        (op_b),
    .sub      (op_sub),
    .result   (sum),
    .overflow (sum_ovf)
  );

  always_comb begin
    state_nxt = state;
    grant_any = 1'b0;
    grant_id  = 1'b0;
    case (state)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          grant_any = 1'b1;
          // Contention goes to the port that did not win last time.
          grant_id  = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
          state_nxt = EXEC;
        end
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Gated by reset_n so no port looks accepted while reset is held.
  assign req0_ready = reset_n && grant_any && !grant_id;
  assign req1_ready = reset_n && grant_any &&  grant_id;
  assign rsp_valid  = (state == RESP);
  assign busy       = (state != IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      op_a         <= '0;
      op_b         <= '0;
      op_sub       <= 1'b0;
      op_id        <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_result   <= '0;
      rsp_overflow <= 1'b0;
      ops_done     <= '0;
    end else begin
      state <= state_nxt;
      if (grant_any) begin
        last_grant <= grant_id;
        op_id      <= grant_id;
        op_a       <= grant_id ? req1_a   : req0_a;
        op_b       <= grant_id ? req1_b   : req0_b;
        op_sub     <= grant_id ? req1_sub : req0_sub;
      end
      if (state == EXEC) begin
        rsp_id       <= op_id;
        rsp_result   <= sum;
        rsp_overflow <= sum_ovf;
      end
      if (state == RESP && rsp_ready && ops_done != {CW{1'b1}})
        ops_done <= ops_done + 1'b1;
    end
  end

endmodule

// File: tb/tb_add_arbiter.sv
module tb_add_arbiter;

  logic        clock, reset_n;
  logic        req0_valid, req0_ready, req0_sub;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_sub;
  logic [31:0] req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_overflow, busy;
  logic [31:0] rsp_result;
  logic [15:0] ops_done;

  logic        s_r0, s_r1, s_rv, s_id, s_ovf, s_busy;
  logic [31:0] s_res;
  logic [1:0]  sat_ops_done;

  int tests = 0;
  int fails = 0;

  typedef struct { bit id; logic [31:0] res; bit ovf; } exp_t;
  exp_t sb[$];

  add_arbiter #(.DW(32), .CW(16)) u_dut (
    .clock(clock), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_overflow(rsp_overflow), .busy(busy), .ops_done(ops_done)
  );

  // Same stimulus, narrow counter: exercises ops_done saturation.
  add_arbiter #(.DW(32), .CW(2)) u_sat (
    .clock(clock), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(s_r0), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(s_r1), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
    .rsp_valid(s_rv), .rsp_ready(rsp_ready), .rsp_id(s_id), .rsp_result(s_res),
    .rsp_overflow(s_ovf), .busy(s_busy), .ops_done(sat_ops_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: 64-bit signed arithmetic; overflow when bits 32 and 31 disagree.
  function automatic exp_t model(bit id, logic [31:0] a, logic [31:0] b, bit sub);
    longint sa, sb_, r;
    exp_t m;
    sa = $signed(a);
    sb_ = $signed(b);
    r = sub ? sa - sb_ : sa + sb_;
    m.id = id;
    m.res = r[31:0];
    m.ovf = (r[32] != r[31]);
    return m;
  endfunction

  // Scoreboard: push at grant, pop and compare at response handshake.
  always @(negedge clock) begin
    if (reset_n) begin
      if (req0_ready) sb.push_back(model(1'b0, req0_a, req0_b, req0_sub));
      if (req1_ready) sb.push_back(model(1'b1, req1_a, req1_b, req1_sub));
      if (rsp_valid && rsp_ready) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL sb_underflow: response id=%0d res=%h with no expectation", rsp_id, rsp_result);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (rsp_id !== e.id || rsp_result !== e.res || rsp_overflow !== e.ovf) begin
            fails++;
            $display("FAIL rsp: got id=%0d res=%h ovf=%0d, want id=%0d res=%h ovf=%0d",
                     rsp_id, rsp_result, rsp_overflow, e.id, e.res, e.ovf);
          end
        end
      end
    end
  end

  task automatic issue(input bit port, input logic [31:0] a, input logic [31:0] b,
                       input bit sub, output bit ok);
    ok = 1'b0;
    @(posedge clock); #1;
    if (port) begin req1_valid = 1; req1_a = a; req1_b = b; req1_sub = sub; end
    else      begin req0_valid = 1; req0_a = a; req0_b = b; req0_sub = sub; end
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (port ? req1_ready : req0_ready) begin ok = 1'b1; break; end
    end
    @(posedge clock); #1;
    req0_valid = 0; req1_valid = 0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (!busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    req0_valid = 1; req1_valid = 1;
    #12;
    @(negedge clock);
    tests++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin fails++;
      $display("FAIL reset_ready: got %0d%0d want 00", req0_ready, req1_ready); end
    tests++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin fails++;
      $display("FAIL reset_valid_busy: got %0d%0d want 00", rsp_valid, busy); end
    tests++; if (rsp_result !== 32'h0 || rsp_id !== 1'b0 || rsp_overflow !== 1'b0) begin fails++;
      $display("FAIL reset_rsp: got id=%0d res=%h ovf=%0d want 0", rsp_id, rsp_result, rsp_overflow); end
    tests++; if (ops_done !== 16'd0 || sat_ops_done !== 2'd0) begin fails++;
      $display("FAIL reset_ops: got %0d/%0d want 0", ops_done, sat_ops_done); end
    req0_valid = 0; req1_valid = 0;
    @(posedge clock); #1 reset_n = 1;
    @(negedge clock);
    tests++; if (busy !== 1'b0 || req0_ready !== 1'b0) begin fails++;
      $display("FAIL reset_idle: got busy=%0d ready0=%0d want 0", busy, req0_ready); end
  endtask

  task automatic test_basic;
    bit ok;
    issue(0, 32'd5, 32'd3, 0, ok);
    tests++; if (!ok) begin fails++; $display("FAIL basic_grant: got no grant, want grant"); end
    @(negedge clock);
    tests++; if (rsp_valid !== 1'b0 || busy !== 1'b1 || req0_ready !== 1'b0) begin fails++;
      $display("FAIL basic_exec: got rv=%0d busy=%0d r0=%0d want 0 1 0", rsp_valid, busy, req0_ready); end
    @(negedge clock);
    tests++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 32'd8) begin fails++;
      $display("FAIL basic_latency: got rv=%0d id=%0d res=%h want 1 0 8", rsp_valid, rsp_id, rsp_result); end
    wait_done(ok);
    tests++; if (ops_done !== 16'd1) begin fails++;
      $display("FAIL basic_ops: got %0d want 1", ops_done); end
  endtask

  task automatic test_overflow;
    bit ok;
    issue(1, 32'h7FFF_FFFF, 32'd1, 0, ok);
    repeat (2) @(negedge clock);
    tests++; if (rsp_result !== 32'h8000_0000 || rsp_overflow !== 1'b1 || rsp_id !== 1'b1) begin fails++;
      $display("FAIL ovf_add: got res=%h ovf=%0d id=%0d want 80000000 1 1", rsp_result, rsp_overflow, rsp_id); end
    wait_done(ok);
    issue(1, 32'h8000_0000, 32'd1, 1, ok);
    repeat (2) @(negedge clock);
    tests++; if (rsp_result !== 32'h7FFF_FFFF || rsp_overflow !== 1'b1) begin fails++;
      $display("FAIL ovf_sub: got res=%h ovf=%0d want 7fffffff 1", rsp_result, rsp_overflow); end
    wait_done(ok);
    issue(0, 32'h8000_0000, 32'd0, 1, ok);
    repeat (2) @(negedge clock);
    tests++; if (rsp_result !== 32'h8000_0000 || rsp_overflow !== 1'b0) begin fails++;
      $display("FAIL ovf_none: got res=%h ovf=%0d want 80000000 0", rsp_result, rsp_overflow); end
    wait_done(ok);
  endtask

  task automatic test_round_robin;
    bit ok, id;
    time t_prev, t_now;
    reset_n = 0; #1 sb.delete();
    req0_a = 32'd10; req0_b = 32'd1; req0_sub = 0;
    req1_a = 32'd20; req1_b = 32'd7; req1_sub = 1;
    req0_valid = 1; req1_valid = 1;
    @(posedge clock); #1 reset_n = 1;
    t_prev = 0;
    for (int g = 0; g < 4; g++) begin
      ok = 0;
      for (int c = 0; c < 10; c++) begin
        @(negedge clock);
        if (req0_ready || req1_ready) begin ok = 1; break; end
      end
      t_now = $time;
      id = req1_ready;
      tests++; if (!ok || (req0_ready && req1_ready) || id !== g[0]) begin fails++;
        $display("FAIL rr_order[%0d]: got r0=%0d r1=%0d want port %0d", g, req0_ready, req1_ready, g[0]); end
      if (g > 0) begin
        tests++; if (t_now - t_prev != 30) begin fails++;
          $display("FAIL rr_interval[%0d]: got %0t want 30", g, t_now - t_prev); end
      end
      t_prev = t_now;
    end
    @(posedge clock); #1 req0_valid = 0; req1_valid = 0;
    wait_done(ok);
    tests++; if (ops_done !== 16'd4) begin fails++;
      $display("FAIL rr_ops: got %0d want 4", ops_done); end
  endtask

  task automatic test_backpressure;
    bit ok;
    logic [31:0] res0;
    logic [15:0] ops0;
    logic id0, ovf0;
    rsp_ready = 0;
    issue(1, 32'h1234_5678, 32'h1111_1111, 1, ok);
    repeat (2) @(negedge clock);
    res0 = rsp_result; id0 = rsp_id; ovf0 = rsp_overflow; ops0 = ops_done;
    tests++; if (rsp_valid !== 1'b1 || res0 !== 32'h0123_4567) begin fails++;
      $display("FAIL bp_resp: got rv=%0d res=%h want 1 01234567", rsp_valid, res0); end
    for (int c = 0; c < 5; c++) begin
      @(posedge clock); #1;
      req0_valid = 1; req0_a = 32'd1; req0_b = 32'd1; req0_sub = 0;
      @(negedge clock);
      tests++;
      if (rsp_valid !== 1'b1 || rsp_result !== res0 || rsp_id !== id0 || rsp_overflow !== ovf0 ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0 || ops_done !== ops0) begin
        fails++;
        $display("FAIL bp_hold[%0d]: got rv=%0d res=%h r0=%0d r1=%0d ops=%0d want 1 %h 0 0 %0d",
                 c, rsp_valid, rsp_result, req0_ready, req1_ready, ops_done, res0, ops0);
      end
    end
    @(posedge clock); #1 rsp_ready = 1; req0_valid = 0;
    @(negedge clock);
    @(posedge clock); #1;
    @(negedge clock);
    tests++; if (ops_done !== ops0 + 16'd1 || busy !== 1'b0) begin fails++;
      $display("FAIL bp_release: got ops=%0d busy=%0d want %0d 0", ops_done, busy, ops0 + 16'd1); end
  endtask

  task automatic test_reset_mid_exec;
    bit ok;
    issue(0, 32'd10, 32'd20, 0, ok);
    reset_n = 0; #1 sb.delete();
    @(negedge clock);
    tests++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || ops_done !== 16'd0) begin fails++;
      $display("FAIL abort: got rv=%0d busy=%0d ops=%0d want 0 0 0", rsp_valid, busy, ops_done); end
    @(posedge clock); #1;
    req0_a = 32'd100; req0_b = 32'd1; req0_sub = 1;
    req1_a = 32'd2;   req1_b = 32'd2; req1_sub = 0;
    req0_valid = 1; req1_valid = 1; reset_n = 1;
    @(negedge clock);
    tests++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0 || rsp_valid !== 1'b0) begin fails++;
      $display("FAIL abort_regrant: got r0=%0d r1=%0d rv=%0d want 1 0 0", req0_ready, req1_ready, rsp_valid); end
    @(posedge clock); #1 req0_valid = 0; req1_valid = 0;
    wait_done(ok);
    tests++; if (ops_done !== 16'd1) begin fails++;
      $display("FAIL abort_ops: got %0d want 1", ops_done); end
  endtask

  task automatic test_saturation;
    bit ok;
    @(posedge clock); #1 reset_n = 0; sb.delete();
    @(posedge clock); #1 reset_n = 1;
    for (int k = 1; k <= 5; k++) begin
      issue(0, k, k, 0, ok);
      wait_done(ok);
      tests++; if (!ok || sat_ops_done !== ((k > 3) ? 2'd3 : 2'(k))) begin fails++;
        $display("FAIL sat[%0d]: got %0d want %0d", k, sat_ops_done, (k > 3) ? 3 : k); end
    end
    tests++; if (ops_done !== 16'd5) begin fails++;
      $display("FAIL sat_wide: got %0d want 5", ops_done); end
  endtask

  task automatic test_random;
    bit ok;
    for (int n = 0; n < 8; n++) begin
      issue(1'($urandom_range(1)), $urandom, $urandom, 1'($urandom_range(1)), ok);
      wait_done(ok);
      tests++; if (!ok) begin fails++; $display("FAIL rand_done[%0d]: got busy want idle", n); end
    end
    tests++; if (sb.size() != 0) begin fails++;
      $display("FAIL sb_leftover: got %0d entries want 0", sb.size()); end
  endtask

  initial begin
    reset_n = 0; rsp_ready = 1;
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_sub = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_sub = 0;
    test_reset;
    test_basic;
    test_overflow;
    test_round_robin;
    test_backpressure;
    test_reset_mid_exec;
    test_saturation;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
